// File: rtl/stage_fifo_scheduler_pkg.sv
// Shared definitions for the stage FIFO scheduler.
//   STAGE_FIFO_SIZE_WIDTH : default pointer width of each stage FIFO
//   sched_state_t         : output-register FSM state
//   ptr_diff()            : modulo-2**width pointer difference used for count/full
package stage_fifo_scheduler_pkg;

  localparam int STAGE_FIFO_SIZE_WIDTH = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } sched_state_t;

  // (a - b) mod 2**width; the pointers are zero-extended to 32 bits by the caller.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/stage_fifo_queue.sv
// One stage FIFO: storage plus wr/rd pointers. One slot is always left
// empty so that wr == rd unambiguously means empty; usable capacity is SIZE-1.
// Ports:
//   clk, resetn      : clock, async active-low reset (pointers only)
//   push, push_data  : write request; ignored while full
//   pop              : advance rd; ignored while empty
//   full, empty      : status from registered pointers
//   count            : occupancy (wr - rd) mod SIZE
//   head             : entry at rd
module stage_fifo_queue
  import stage_fifo_scheduler_pkg::*;
#(
  parameter int WIDTH      = STAGE_FIFO_SIZE_WIDTH,
  parameter int SIZE       = 2**WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [WIDTH-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0]      wr;
  logic [WIDTH-1:0]      rd;
  logic                  push_en;
  logic                  pop_en;

  assign count   = WIDTH'(ptr_diff(32'(wr), 32'(rd), WIDTH));
  assign full    = (ptr_diff(32'(rd), 32'(wr), WIDTH) == 32'd1);
  assign empty   = (wr == rd);
  assign head    = mem[rd];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push_en) wr <= wr + 1'b1;
      if (pop_en)  rd <= rd + 1'b1;
    end
  end

  // Storage needs no reset: slots are only read between rd and wr.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr] <= push_data;
  end

endmodule

// File: rtl/stage_fifo_scheduler.sv
// Shared-stage scheduler: NUM_REQ producer FIFOs drained round-robin into
// one registered valid/ready output.
// Ports:
//   clk, resetn              : clock, async active-low reset
//   push_valid/data/ready    : per-producer push interface (ready = not full)
//   out_valid/data/src       : registered output entry and its source FIFO
//   out_ready                : downstream accept
//   fifo_count               : per-FIFO occupancy, WIDTH bits each
//
// state | meaning
// EMPTY | output register free; any non-empty FIFO is popped
// HOLD  | out_valid high, entry held until out_ready
module stage_fifo_scheduler
  import stage_fifo_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = STAGE_FIFO_SIZE_WIDTH,
  parameter int SIZE       = 2**WIDTH,
  parameter int DATA_WIDTH = 32,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            push_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] push_data,
  output logic [NUM_REQ-1:0]            push_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          out_ready,
  output logic [NUM_REQ*WIDTH-1:0]      fifo_count
);

  sched_state_t          state;
  sched_state_t          state_nxt;
  logic [NUM_REQ-1:0]    full;
  logic [NUM_REQ-1:0]    empty;
  logic [NUM_REQ-1:0]    pop_vec;
  logic [DATA_WIDTH-1:0] head_arr [NUM_REQ];
  logic [SRC_W-1:0]      last_grant;
  logic [SRC_W-1:0]      grant;
  logic                  found;
  logic                  pop_opp;
  logic                  load;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
    stage_fifo_queue #(
      .WIDTH      (WIDTH),
      .SIZE       (SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_q (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push_valid[i]),
      .push_data (push_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (pop_vec[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (fifo_count[i*WIDTH +: WIDTH]),
      .head      (head_arr[i])
    );
  end

  assign push_ready = ~full;
  assign pop_opp    = (state == EMPTY) || out_ready;

  // Round-robin search starting just after the last grant. Uses the
  // pre-edge empty flags, so a same-edge push is never seen here.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pop_opp) state_nxt = found ? HOLD : EMPTY;
  end

  always_comb begin
    out_valid = (state == HOLD);
    pop_vec   = '0;
    load      = 1'b0;
    if (pop_opp && found) begin
      pop_vec[grant] = 1'b1;
      load           = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SRC_W'(NUM_REQ - 1);
    end else if (load) begin
      out_data   <= head_arr[grant];
      out_src    <= grant;
      last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_stage_fifo_scheduler.sv
module tb_stage_fifo_scheduler;

  logic         clk;
  logic         resetn;
  logic [3:0]   push_valid;
  logic [127:0] push_data;
  logic [3:0]   push_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_ready;
  logic [7:0]   fifo_count;

  int vec_count  = 0;
  int miss_count = 0;

  stage_fifo_scheduler #(
    .NUM_REQ    (4),
    .WIDTH      (2),
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pv;
    logic [31:0] d;     // lane i receives d + 16*i
    logic        ordy;
    logic [3:0]  e_pr;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_src;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t fill_tab [9];
  vec_t rr_tab   [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] pv, input logic [31:0] l0, input logic [31:0] l1,
                       input logic [31:0] l2, input logic [31:0] l3, input logic ordy);
    @(negedge clk);
    push_valid = pv;
    push_data  = {l3, l2, l1, l0};
    out_ready  = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    drive(v.pv, v.d, v.d + 32'h10, v.d + 32'h20, v.d + 32'h30, v.ordy);
    step();
    check({tag, ".push_ready"}, 32'(push_ready), 32'(v.e_pr));
    check({tag, ".out_valid"},  32'(out_valid),  32'(v.e_ov));
    check({tag, ".fifo_count"}, 32'(fifo_count), 32'(v.e_cnt));
    if (v.e_ov) begin
      check({tag, ".out_data"}, out_data,       v.e_od);
      check({tag, ".out_src"},  32'(out_src),   32'(v.e_src));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"},  32'(out_valid),  32'd0);
    check({tag, ".push_ready"}, 32'(push_ready), 32'hF);
    check({tag, ".fifo_count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    //            pv       d    ordy  pr    ov   od   src  cnt
    fill_tab[0] = '{4'b0001, 32'd0, 1'b0, 4'hF, 1'b0, 32'd0, 2'd0, 8'h01};
    fill_tab[1] = '{4'b0001, 32'd1, 1'b0, 4'hF, 1'b1, 32'd0, 2'd0, 8'h01};
    fill_tab[2] = '{4'b0001, 32'd2, 1'b0, 4'hF, 1'b1, 32'd0, 2'd0, 8'h02};
    fill_tab[3] = '{4'b0001, 32'd3, 1'b0, 4'hE, 1'b1, 32'd0, 2'd0, 8'h03};
    fill_tab[4] = '{4'b0001, 32'd4, 1'b0, 4'hE, 1'b1, 32'd0, 2'd0, 8'h03};
    // push into the full FIFO on the popping edge: rejected, 3 -> 2
    fill_tab[5] = '{4'b0001, 32'd5, 1'b1, 4'hF, 1'b1, 32'd1, 2'd0, 8'h02};
    fill_tab[6] = '{4'b0000, 32'd0, 1'b1, 4'hF, 1'b1, 32'd2, 2'd0, 8'h01};
    fill_tab[7] = '{4'b0000, 32'd0, 1'b1, 4'hF, 1'b1, 32'd3, 2'd0, 8'h00};
    fill_tab[8] = '{4'b0000, 32'd0, 1'b1, 4'hF, 1'b0, 32'd0, 2'd0, 8'h00};

    rr_tab[0] = '{4'b1111, 32'hA0, 1'b1, 4'hF, 1'b0, 32'h00, 2'd0, 8'h55};
    rr_tab[1] = '{4'b1111, 32'hA1, 1'b1, 4'hF, 1'b1, 32'hA0, 2'd0, 8'hA9};
    rr_tab[2] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b1, 32'hB0, 2'd1, 8'hA5};
    rr_tab[3] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b1, 32'hC0, 2'd2, 8'h95};
    rr_tab[4] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b1, 32'hD0, 2'd3, 8'h55};
    rr_tab[5] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b1, 32'hA1, 2'd0, 8'h54};
    rr_tab[6] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b1, 32'hB1, 2'd1, 8'h50};
    rr_tab[7] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b1, 32'hC1, 2'd2, 8'h40};
    rr_tab[8] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b1, 32'hD1, 2'd3, 8'h00};
    rr_tab[9] = '{4'b0000, 32'h00, 1'b1, 4'hF, 1'b0, 32'h00, 2'd0, 8'h00};

    // reset held while every producer pushes
    resetn     = 1'b0;
    push_valid = 4'hF;
    push_data  = {4{32'hDEAD_BEEF}};
    out_ready  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_idle($sformatf("rst_push%0d", c));
    end
    check("rst.out_data", out_data, 32'd0);
    check("rst.out_src", 32'(out_src), 32'd0);
    drive(4'h0, 0, 0, 0, 0, 1'b0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(fill_tab[i], $sformatf("fill%0d", i));

    // reset mid-operation drops queued entries and the held output
    drive(4'hF, 32'h50, 32'h60, 32'h70, 32'h80, 1'b0);
    step();
    drive(4'hF, 32'h51, 32'h61, 32'h71, 32'h81, 1'b0);
    step();
    check("midrst.pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    push_valid = 4'h0;
    resetn = 1'b0;
    #1;
    check_idle("midrst.async");
    step();
    check_idle("midrst.held");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(rr_tab[i], $sformatf("rr%0d", i));

    // back-pressure: 0x1234 held for 5 cycles, no FIFO popped
    drive(4'b0010, 0, 32'h1234, 0, 0, 1'b0);
    step();
    check("bp.load_cnt", 32'(fifo_count), 32'h04);
    drive(4'b0110, 0, 32'h99, 32'h55, 0, 1'b0);
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(4'h0, 0, 0, 0, 0, 1'b0);
      else step();
      if (c == 0) step();
      check($sformatf("bp%0d.out_data", c), out_data, 32'h1234);
      check($sformatf("bp%0d.out_src", c), 32'(out_src), 32'd1);
      check($sformatf("bp%0d.out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d.fifo_count", c), 32'(fifo_count), 32'h14);
    end
    drive(4'h0, 0, 0, 0, 0, 1'b1);
    step();
    check("bp_rel0.out_data", out_data, 32'h55);
    check("bp_rel0.out_src", 32'(out_src), 32'd2);
    check("bp_rel0.fifo_count", 32'(fifo_count), 32'h04);
    step();
    check("bp_rel1.out_data", out_data, 32'h99);
    check("bp_rel1.out_src", 32'(out_src), 32'd1);
    check("bp_rel1.fifo_count", 32'(fifo_count), 32'h00);

    // pointer wrap: 20 push/pop pairs on FIFO 2
    for (int k = 0; k < 20; k++) begin
      drive(4'b0100, 0, 0, 32'h300 + 32'(k), 0, 1'b1);
      step();
      if (k == 0) begin
        check("wrap0.out_valid", 32'(out_valid), 32'd0);
      end else begin
        check($sformatf("wrap%0d.out_data", k), out_data, 32'h300 + 32'(k - 1));
        check($sformatf("wrap%0d.out_src", k), 32'(out_src), 32'd2);
      end
      check($sformatf("wrap%0d.count_le3", k), 32'(fifo_count[5:4] <= 2'd3 && fifo_count[5:4] == 2'd1), 32'd1);
    end
    drive(4'h0, 0, 0, 0, 0, 1'b1);
    step();
    check("wrap_last.out_data", out_data, 32'h313);
    check("wrap_last.fifo_count", 32'(fifo_count), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
